// File: rtl/im_loader.sv
// Instruction-memory loader: takes 32-bit words over a valid/ready port and writes them
// as four little-endian byte writes. Optional running checksum port: IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned MEM_BYTES = 44
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [2:0]  dbg_state
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        ovf_q, ovf_d;

  logic [32:0] end_addr;
  logic        word_fits;
  logic        xfer;
  logic [1:0]  next_idx;

  // Handshake: a word transfers on a rising edge where word_valid && word_ready are both
  // high; word_ready is a pure decode of ACCEPT, so it never depends on word_valid.
  assign word_ready = (state_q == ST_ACCEPT);
  assign xfer       = word_ready && word_valid;

  // The range check uses 33 bits so an address near 2^32 cannot wrap into range.
  assign end_addr  = {1'b0, cur_addr_q} + 33'd3;
  assign word_fits = (end_addr <= LAST_ADDR);
  assign next_idx  = idx_q + 2'd1;

  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  assign checksum = csum_q;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    idx_d       = idx_q;
    word_d      = word_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ovf_d       = ovf_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d = base_addr;
          ovf_d      = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d     = 32'd0;
`endif
          state_d    = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (xfer) begin
          if (word_fits) begin
            // Byte 0 is staged here so it is on the registered outputs in the first WRITE cycle.
            word_d      = word_data;
            last_d      = word_last;
            idx_d       = 2'd0;
            mem_addr_d  = cur_addr_q;
            mem_wdata_d = word_data[7:0];
`ifdef IM_LOADER_CHECKSUM_EN
            csum_d      = csum_q + word_data;
`endif
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_WRITE: begin
        if (idx_q == 2'd3) begin
          cur_addr_d = cur_addr_q + 32'd4;
          idx_d      = 2'd0;
          state_d    = last_q ? ST_DONE : ST_ACCEPT;
        end else begin
          idx_d       = next_idx;
          mem_addr_d  = cur_addr_q + {30'd0, next_idx};
          mem_wdata_d = word_q[{next_idx, 3'b000} +: 8];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        ovf_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= 32'd0;
      idx_q       <= 2'd0;
      word_q      <= 32'd0;
      last_q      <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 8'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 32'd0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: a session-level reference model predicts byte writes,
// done/overflow outcome and timing; a negedge monitor scores the memory write stream.
module tb_im_loader;

  localparam int unsigned MEM_BYTES = 44;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [2:0]  dbg_state;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  im_loader #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_data_q[$];
  logic [31:0] wbuf[16];
  logic [31:0] exp_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every byte write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_addr[23:0], mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", mem_addr, exp_q.pop_front());
        check("wr_data", {24'd0, mem_wdata}, {24'd0, exp_data_q.pop_front()});
      end
    end
  end

  // Reference model + driver for one session using wbuf[0..n-1].
  task automatic run_session(input logic [31:0] base, input int n, input int gap_max,
                             input bit poke_start, input bit timed);
    logic [32:0] a;
    int n_accept, xfers, budget, t0, g;
    bit exp_done, exp_ovf, aborted;
    a = {1'b0, base};
    n_accept = 0; exp_done = 0; exp_ovf = 0; exp_sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      n_accept++;
      if (a + 33'd3 <= 33'(MEM_BYTES - 1)) begin
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back(a[31:0] + 32'(k));
          exp_data_q.push_back(8'(wbuf[i] >> (8 * k)));
        end
        exp_sum = exp_sum + wbuf[i];
        a = a + 33'd4;
        if (i == n - 1) exp_done = 1;
      end else begin
        exp_ovf = 1;
        break;
      end
    end

    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(negedge clk);
    start = 1'b0; base_addr = 32'($urandom);
    check("ovf_clear_on_start", overflow, 1'b0);
    check("busy_after_start", busy, 1'b1);

    xfers = 0; aborted = 0; t0 = 0;
    for (int i = 0; i < n && !aborted; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      word_valid = 1'b0;
      repeat (g) @(negedge clk);
      word_valid = 1'b1; word_data = wbuf[i]; word_last = (i == n - 1);
      budget = 20;
      while (!word_ready && busy && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!busy) begin
        aborted = 1;
      end else if (budget == 0) begin
        check("ready_timeout", 32'd0, 32'd1);
        aborted = 1;
      end else begin
        @(posedge clk);
        #1;
        if (i == 0) t0 = cyc;
        xfers++;
        @(negedge clk);
        word_valid = 1'b0;
        word_data = 32'($urandom);
        if (poke_start) begin
          start = 1'b1; base_addr = 32'($urandom_range(0, 40));
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    word_valid = 1'b0;

    budget = 60;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("session_end_timeout", 32'(budget == 0), 32'd0);
    if (timed) check("latency_to_idle", 32'(cyc - t0), 32'(5 * n));
    repeat (2) @(negedge clk);
    check("words_accepted", 32'(xfers), 32'(n_accept));
    check("writes_left", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    check("overflow", overflow, 32'(exp_ovf));
    check("busy_idle", busy, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    exp_q.delete();
    exp_data_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_ready"}, word_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
`ifdef IM_LOADER_CHECKSUM_EN
    check({tag, "_csum"}, checksum, 32'd0);
`endif
  endtask

  // Reset asserted while byte 2 of a word is on the bus.
  task automatic reset_mid_write();
    int budget;
    wbuf[0] = 32'($urandom);
    @(negedge clk);
    start = 1'b1; base_addr = 32'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'(k));
      exp_data_q.push_back(8'(wbuf[0] >> (8 * k)));
    end
    word_valid = 1'b1; word_data = wbuf[0]; word_last = 1'b1;
    budget = 20;
    while (!(mem_we && mem_addr == 32'd2) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (word_ready == 1'b0) word_valid = 1'b0;
    end
    check("byte2_reached", 32'(budget > 0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_write");
    check("rst_bytes_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    exp_data_q.delete();
    word_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_release_idle", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 32'd0;
    word_valid = 1'b0; word_data = 32'd0; word_last = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single word at address 0
    wbuf[0] = 32'h0080_0293;
    run_session(32'd0, 1, 0, 0, 1);

    // fill the whole memory back-to-back
    for (int i = 0; i < 10; i++) wbuf[i] = 32'($urandom);
    wbuf[10] = 32'h0122_a023;
    run_session(32'd0, 11, 0, 0, 1);

    // second word runs past the end
    wbuf[0] = 32'($urandom); wbuf[1] = 32'($urandom);
    run_session(32'd40, 2, 0, 0, 0);
    check("ovf_sticky", overflow, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ovf_async_reset", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    reset_mid_write();

    // gaps in word_valid with start poked during WRITE
    for (int i = 0; i < 3; i++) wbuf[i] = 32'($urandom);
    run_session(32'd4, 3, 2, 1, 0);

    wbuf[0] = 32'h0080_0293; wbuf[1] = 32'h00f0_0313;
    run_session(32'd0, 2, 1, 0, 0);
`ifdef IM_LOADER_CHECKSUM_EN
    check("checksum_known", checksum, 32'h0170_05A6);
`endif

    for (int s = 0; s < 20; s++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 32'($urandom);
      run_session(32'($urandom_range(0, MEM_BYTES + 4)), n, int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter MEM_BYTES, default 44, is the byte capacity of the target instruction memory (valid addresses 0..MEM_BYTES-1).
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 Port start  input  1  begins a load session; sampled only in IDLE.
REQ-005 Port base_addr  input  32  is the byte address of the first word, sampled with start.
REQ-006 Port word_valid  input  1  means the producer offers word_data/word_last.
REQ-007 Port word_data  input  32  is the instruction word to store.
REQ-008 Port word_last  input  1  marks the final word of the session.
REQ-009 Port word_ready  output  1  means the loader accepts a word this cycle.
REQ-010 Port mem_we  output  1  is the byte write strobe to the instruction memory.
REQ-011 Port mem_addr  output  32  is the byte write address.
REQ-012 Port mem_wdata  output  8  is the byte write data.
REQ-013 Port busy  output  1  is high in every state except IDLE.
REQ-014 Port done  output  1  is a one-cycle pulse on successful session end.
REQ-015 Port overflow  output  1  is a sticky error flag for an out-of-range word.

Function
REQ-016 The FSM SHALL have states IDLE, ACCEPT, WRITE, DONE, ERR.
REQ-017 In IDLE, start=1 SHALL load cur_addr<=base_addr, clear overflow, and enter ACCEPT next cycle; start outside IDLE SHALL be ignored.
REQ-018 word_ready SHALL equal 1 only in ACCEPT; a word transfers on a cycle with word_valid=1 and word_ready=1.
REQ-019 On transfer, if cur_addr+3 (computed in 33 bits) <= MEM_BYTES-1, the FSM SHALL enter WRITE with byte index 0; otherwise it SHALL enter ERR with no memory write.
REQ-020 In WRITE, for byte index k=0..3 on consecutive cycles, mem_we SHALL be 1, mem_addr SHALL be cur_addr+k, mem_wdata SHALL be word_data[8k+7:8k] (little-endian).
REQ-021 After k=3, cur_addr SHALL advance by 4; next state SHALL be DONE if the captured word_last was 1, else ACCEPT.
REQ-022 Latency: byte 0 is written the cycle after transfer; sustained rate is one word per 5 cycles; word_valid gaps only extend ACCEPT.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 ERR SHALL set overflow=1 and return to IDLE next cycle; overflow SHALL hold until the next accepted start or reset.
REQ-025 mem_we SHALL be 0 in every state other than WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL be registered outputs.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force IDLE, mem_we=0, word_ready=0, busy=0, done=0, overflow=0, mem_addr=0, mem_wdata=0, cur_addr=0, byte index=0.
REQ-027 Reset mid-WRITE SHALL abort the word with no further byte writes; release returns to IDLE awaiting start.

Configuration
REQ-028 When macro IM_LOADER_CHECKSUM_EN is defined, port checksum  output  32 SHALL exist, cleared to 0 at reset and at accepted start, and incremented mod 2^32 by word_data on each transfer that enters WRITE.
REQ-029 When IM_LOADER_CHECKSUM_EN is undefined, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 start, base_addr=0, one word 0x00800293 with word_last=1 -> writes 93@0, 02@1, 80@2, 00@3 on four consecutive cycles, then done pulse, busy low.
REQ-031 base_addr=0, 11 words back-to-back, last on word 11 (0x0122a023) -> 44 byte writes, final 01@43, one done pulse, overflow=0, 55 cycles from first transfer to IDLE.
REQ-032 base_addr=40, two words -> first word written at 40..43; second word accepted, no write, overflow=1, no done; overflow cleared by next start.
REQ-033 rst_n low during WRITE byte 2 -> mem_we drops same cycle, no write of byte 3, all outputs at reset values.
REQ-034 word_valid toggled 1-0-0-1 with start pulsed during WRITE -> no byte lost or duplicated, start ignored, addresses contiguous.
REQ-035 With IM_LOADER_CHECKSUM_EN, words 0x00800293 and 0x00f00313 -> checksum=0x017005A6 at done.
